// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory port arbiter.
//   owner_e      : tag identifying which requester owns an in-flight read
//   MEM_DATA_W   : memory read data width
//   STARVE_CNT_W : width of the fetch starvation counter
package v850_mem_pkg;

  localparam int MEM_DATA_W   = 64;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_resp_tracker.sv
// mem_resp_tracker: MEM_LAT-deep shift register of read owner tags.
// Memory latency is fixed, so the tag pushed with a grant reaches the head
// exactly when its read data arrives.
//   clk, rst_n : clock, async active-low reset (clears all tags to OWN_NONE)
//   push_tag   : owner of the access granted this cycle (OWN_NONE if none/write)
//   head_tag   : owner of the read data on mem_rdata_i this cycle
module mem_resp_tracker
  import v850_mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_e push_tag,
  output owner_e head_tag
);

  logic [MEM_LAT-1:0][1:0] tag_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= push_tag;
      for (int i = 1; i < MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign head_tag = owner_e'(tag_pipe[MEM_LAT-1]);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between instruction fetch
// and the load/store unit. Data has priority; a starvation counter forces a
// fetch grant after STARVE_MAX consecutive denied fetch cycles.
//   if_*   : fetch read request / grant / response
//   dm_*   : data read/write request / grant / response
//   mem_*  : memory port (byte address, strobe, write data/enables, read data)
// Grants are combinational and only issued while mem_ready_i is high.
module mem_port_arbiter
  import v850_mem_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [MEM_DATA_W-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [31:0]           dm_wdata_i,
  input  logic [3:0]            dm_be_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [MEM_DATA_W-1:0] dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W:0]       mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_ready_i,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    if_win;
  logic                    dm_wr;
  owner_e                  push_tag;
  owner_e                  head_tag;

  always_comb begin
    if_win   = if_req_i && (!dm_req_i || starve_cnt == STARVE_LIM);
    // rst_n gates the grants so every output reads 0 while reset is held,
    // even if requesters keep their requests up.
    if_gnt_o = rst_n && mem_ready_i && if_win;
    dm_gnt_o = rst_n && mem_ready_i && dm_req_i && !if_win;
    dm_wr    = dm_gnt_o && dm_we_i;

    mem_req_o   = if_gnt_o || dm_gnt_o;
    mem_we_o    = dm_wr;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    push_tag    = OWN_NONE;
    if (if_gnt_o) begin
      mem_addr_o = {if_addr_i, 1'b0};
      push_tag   = OWN_IF;
    end else if (dm_gnt_o) begin
      mem_addr_o = {dm_addr_i, 1'b0};
      if (dm_wr) begin
        mem_wdata_o = dm_wdata_i;
        mem_be_o    = dm_be_i;
      end else begin
        push_tag = OWN_DM;
      end
    end
  end

  // Denied fetch cycles count whether lost to data or to a memory stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      starve_cnt <= '0;
    else if (!if_req_i || if_gnt_o)  starve_cnt <= '0;
    else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
  end

  mem_resp_tracker #(.MEM_LAT(MEM_LAT)) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_tag (push_tag),
    .head_tag (head_tag)
  );

  assign if_rvalid_o = (head_tag == OWN_IF);
  assign dm_rvalid_o = (head_tag == OWN_DM);
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 3) share one
// stimulus stream and a byte-addressed memory model. A reference model of the
// arbitration rules and an independent reference memory predict grants,
// memory port values and per-latency read responses.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;
  localparam int NCYC = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        if_req, dm_req, dm_we, mem_ready;
  logic [24:0] if_addr, dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;

  logic        if_gnt [3], if_rv [3], dm_gnt [3], dm_rv [3], mo_req [3], mo_we [3];
  logic [63:0] if_rd [3], dm_rd [3];
  logic [25:0] mo_addr [3];
  logic [31:0] mo_wd [3];
  logic [3:0]  mo_be [3];
  logic [63:0] pipe [3][4];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(25), .MEM_LAT(k+1), .STARVE_MAX(SMAX)) u (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[k]),
      .if_rvalid_o(if_rv[k]), .if_rdata_o(if_rd[k]),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
      .dm_wdata_i(dm_wdata), .dm_be_i(dm_be), .dm_gnt_o(dm_gnt[k]),
      .dm_rvalid_o(dm_rv[k]), .dm_rdata_o(dm_rd[k]),
      .mem_req_o(mo_req[k]), .mem_we_o(mo_we[k]), .mem_addr_o(mo_addr[k]),
      .mem_wdata_o(mo_wd[k]), .mem_be_o(mo_be[k]),
      .mem_ready_i(mem_ready), .mem_rdata_i(pipe[k][k])
    );
  end

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      0: return 8'hC1; 1: return 8'h11; 2: return 8'h5F; 3: return 8'h12;
      4: return 8'h41; 5: return 8'h21; 6: return 8'hC1; 7: return 8'h1E;
      default: return 8'(a * 37 + 5);
    endcase
  endfunction

  function automatic logic [63:0] read8(input logic [7:0] m [256], input int a);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m[(a + i) % 256];
    return r;
  endfunction

  // Memory seen by the DUTs, driven by instance 0's port (all instances
  // receive the same requests and must grant identically).
  logic [7:0] mem [256];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    logic [63:0] rd;
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_init <= 1'b1;
    end else if (mo_req[0] && mo_we[0]) begin
      for (int i = 0; i < 4; i++)
        if (mo_be[0][i]) mem[(int'(mo_addr[0]) + i) % 256] <= mo_wd[0][i*8 +: 8];
    end
    rd = (mo_req[0] && !mo_we[0]) ? read8(mem, int'(mo_addr[0])) : {$urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      pipe[k][0] <= rd;
      for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end

  // Reference state
  logic [7:0]  ref_mem [256];
  int          starve;
  int          cyc;
  int          exp_own [3][NCYC];   // 0 none, 1 fetch, 2 data
  logic [63:0] exp_dat [3][NCYC];
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_expect();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NCYC; c++) begin exp_own[k][c] = 0; exp_dat[k][c] = '0; end
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model.
  task automatic step(output bit gi, output bit gd);
    bit          fw;
    logic [25:0] ea;
    @(negedge clk);
    fw = if_req && (!dm_req || starve == SMAX);
    gi = mem_ready && fw;
    gd = mem_ready && dm_req && !fw;
    ea = gi ? {if_addr, 1'b0} : gd ? {dm_addr, 1'b0} : '0;
    for (int k = 0; k < 3; k++) begin
      chk("if_gnt", if_gnt[k], gi);
      chk("dm_gnt", dm_gnt[k], gd);
      chk("if_rvalid", if_rv[k], exp_own[k][cyc] == 1);
      chk("dm_rvalid", dm_rv[k], exp_own[k][cyc] == 2);
      chk("one_rvalid", if_rv[k] && dm_rv[k], 0);
      if (exp_own[k][cyc] == 1) chk("if_rdata", if_rd[k], exp_dat[k][cyc]);
      if (exp_own[k][cyc] == 2) chk("dm_rdata", dm_rd[k], exp_dat[k][cyc]);
    end
    chk("mem_req", mo_req[0], gi || gd);
    chk("mem_addr", mo_addr[0], ea);
    chk("mem_we", mo_we[0], gd && dm_we);
    chk("mem_wdata", mo_wd[0], (gd && dm_we) ? dm_wdata : 32'h0);
    chk("mem_be", mo_be[0], (gd && dm_we) ? dm_be : 4'h0);
    if (gi || (gd && !dm_we))
      for (int k = 0; k < 3; k++) begin
        exp_own[k][cyc+k+1] = gi ? 1 : 2;
        exp_dat[k][cyc+k+1] = read8(ref_mem, int'(ea));
      end
    if (gd && dm_we)
      for (int i = 0; i < 4; i++)
        if (dm_be[i]) ref_mem[(int'(ea) + i) % 256] = dm_wdata[i*8 +: 8];
    if (!if_req || gi) starve = 0;
    else if (starve < SMAX) starve++;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_if_gnt"}, if_gnt[k], 0);
      chk({tag, "_dm_gnt"}, dm_gnt[k], 0);
      chk({tag, "_if_rv"}, if_rv[k], 0);
      chk({tag, "_dm_rv"}, dm_rv[k], 0);
      chk({tag, "_mem_req"}, mo_req[k], 0);
      chk({tag, "_mem_we"}, mo_we[k], 0);
      chk({tag, "_mem_addr"}, mo_addr[k], 0);
      chk({tag, "_mem_wd"}, mo_wd[k], 0);
      chk({tag, "_mem_be"}, mo_be[k], 0);
    end
  endtask

  initial begin
    bit gi, gd;
    bit pend_if, pend_dm;
    rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 1;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    starve = 0; cyc = 0;
    clear_expect();
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch-only reads at 0, 4, 8
    if_req = 1; if_addr = 25'd0;
    step(gi, gd);
    chk("fetch0_rv_lat1", g_dut[0].u.if_rvalid_o, 1);
    chk("fetch0_data_lat1", if_rd[0], 64'h1EC1_2141_125F_11C1);
    if_addr = 25'd4; step(gi, gd);
    if_addr = 25'd8; step(gi, gd);
    if_req = 0;
    repeat (4) step(gi, gd);

    // Both requesting: DM x4 then IF, repeating
    if_req = 1; if_addr = 25'h20; dm_req = 1; dm_we = 0; dm_addr = 25'h10;
    for (int i = 0; i < 15; i++) begin
      step(gi, gd);
      chk("pattern_if", gi, (i % 5) == 4);
    end
    if_req = 0; dm_req = 0;
    repeat (4) step(gi, gd);

    // Write then read same address
    dm_req = 1; dm_we = 1; dm_addr = 25'h10; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
    step(gi, gd);
    dm_we = 0; dm_wdata = '0; dm_be = '0;
    step(gi, gd);
    dm_req = 0;
    chk("wr_rd_rv", dm_rv[0], 1);
    chk("wr_rd_data", dm_rd[0][31:0], 32'hDEADBEEF);
    chk("wr_rd_if_rv", if_rv[0], 0);
    repeat (4) step(gi, gd);

    // Stall 3 cycles with both requesting, then DM, then IF
    if_req = 1; dm_req = 1; if_addr = 25'h4; dm_addr = 25'h8; mem_ready = 0;
    repeat (3) begin step(gi, gd); chk("stall_req", mo_req[0], 0); end
    mem_ready = 1;
    step(gi, gd); chk("post_stall_dm", gd, 1);
    step(gi, gd); chk("post_stall_if", gi, 1);
    if_req = 0; dm_req = 0;
    repeat (4) step(gi, gd);

    // Reset one cycle after a fetch read grant
    if_req = 1; if_addr = 25'h0;
    step(gi, gd);
    dm_req = 1;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk); if_req = 0; dm_req = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cyc++;
    starve = 0;
    clear_expect();
    repeat (5) step(gi, gd);

    // Randomized traffic with hold-until-granted requesters
    pend_if = 0; pend_dm = 0;
    for (int i = 0; i < 80; i++) begin
      if (!pend_if) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = 25'($urandom_range(0, 127));
      end
      if (!pend_dm) begin
        dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
        dm_addr = 25'($urandom_range(0, 127)); dm_wdata = $urandom;
        dm_be = 4'($urandom_range(0, 15));
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      step(gi, gd);
      pend_if = if_req && !gi;
      pend_dm = dm_req && !gd;
    end
    if_req = 0; dm_req = 0; mem_ready = 1;
    repeat (4) step(gi, gd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
